// File: rtl/access_checker.sv
// access_checker: key-match stage downstream of the Sensor capture block.
// Each contiguous transfer run (etapa == 2'b11) yields one evaluation of the captured word s2.
// On each evaluation the block does one of three things:
// - stores s2 as the key (when enroll is high);
// - opens a timed access window (when s2 matches the stored key);
// - counts a mismatch, entering a timed lockout once N_TRIES consecutive mismatches are reached.
//
// Build option: define ACCESS_LOCK_STICKY_EN to make the lockout permanent
// (only rst_n leaves LOCKED).
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   s2        3-bit captured sensor word
//   etapa     shared stage code (2'b10 capture, 2'b11 transfer)
//   enroll    level; at an evaluation, store s2 as the key instead of checking it
//   granted   high for GRANT_CYCLES cycles after a match
//   denied    one-cycle pulse per rejected evaluation
//   locked    high during lockout
//   enrolled  high once a key has been stored
//   fail_cnt  consecutive mismatch count (saturating)
module access_checker #(
  parameter int unsigned N_TRIES      = 3,
  parameter int unsigned GRANT_CYCLES = 25_000_000,
  parameter int unsigned LOCK_CYCLES  = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] s2,
  input  logic [1:0] etapa,
  input  logic       enroll,
  output logic       granted,
  output logic       denied,
  output logic       locked,
  output logic       enrolled,
  output logic [2:0] fail_cnt
);

  localparam int unsigned MaxCycles = (GRANT_CYCLES > LOCK_CYCLES) ? GRANT_CYCLES : LOCK_CYCLES;
  // Keep at least one bit so a 1-cycle window still has a legal timer.
  localparam int unsigned TimerW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [TimerW-1:0] GrantLoad = TimerW'(GRANT_CYCLES - 1);
  localparam logic [TimerW-1:0] LockLoad  = TimerW'(LOCK_CYCLES - 1);
  localparam logic [2:0]        NTries    = 3'(N_TRIES);

  typedef enum logic [1:0] {StIdle, StGrant, StLocked} state_e;

  state_e            state;
  logic [1:0]        et_q1, et_q2;
  logic              ev, ev_q;
  logic [TimerW-1:0] timer;
  logic [2:0]        key;
  logic [2:0]        fail_next;

  // Rising edge into a transfer run: one strobe per contiguous run of 2'b11.
  assign ev = (et_q1 == 2'b11) && (et_q2 != 2'b11);

  assign fail_next = (fail_cnt == 3'd7) ? fail_cnt : fail_cnt + 3'd1;

  assign granted = (state == StGrant);
  assign locked  = (state == StLocked);

  // The strobe is registered once more before the decision, so results appear two edges after
  // the edge that first samples etapa == 2'b11.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= StIdle;
      et_q1    <= 2'b00;
      et_q2    <= 2'b00;
      ev_q     <= 1'b0;
      timer    <= '0;
      key      <= 3'b000;
      enrolled <= 1'b0;
      fail_cnt <= 3'd0;
      denied   <= 1'b0;
    end else begin
      et_q1  <= etapa;
      et_q2  <= et_q1;
      ev_q   <= ev;
      denied <= 1'b0;
      case (state)
        StIdle: begin
          if (ev_q) begin
            if (enroll) begin
              key      <= s2;
              enrolled <= 1'b1;
              fail_cnt <= 3'd0;
            end else if (enrolled && (s2 == key)) begin
              state    <= StGrant;
              fail_cnt <= 3'd0;
              timer    <= GrantLoad;
            end else begin
              denied   <= 1'b1;
              fail_cnt <= fail_next;
              if (fail_next == NTries) begin
                state <= StLocked;
                timer <= LockLoad;
              end
            end
          end
        end
        StGrant: begin
          // Strobes during the window are dropped, including one on the expiry cycle.
          if (timer == '0) begin
            state <= StIdle;
          end else begin
            timer <= timer - TimerW'(1);
          end
        end
        StLocked: begin
`ifdef ACCESS_LOCK_STICKY_EN
          fail_cnt <= NTries;
`else
          if (timer == '0) begin
            state    <= StIdle;
            fail_cnt <= 3'd0;
          end else begin
            timer <= timer - TimerW'(1);
          end
`endif
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_access_checker.sv
// Directed bench for access_checker with N_TRIES=3, GRANT_CYCLES=10, LOCK_CYCLES=20.
module tb_access_checker;

  logic       clk;
  logic       rst_n;
  logic [2:0] s2;
  logic [1:0] etapa;
  logic       enroll;
  logic       granted;
  logic       denied;
  logic       locked;
  logic       enrolled;
  logic [2:0] fail_cnt;

  int total = 0;
  int bad   = 0;
  int hc, lc;
  logic dn, gr;

  access_checker #(
    .N_TRIES      (3),
    .GRANT_CYCLES (10),
    .LOCK_CYCLES  (20)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s2       (s2),
    .etapa    (etapa),
    .enroll   (enroll),
    .granted  (granted),
    .denied   (denied),
    .locked   (locked),
    .enrolled (enrolled),
    .fail_cnt (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transfer run of a single cycle; returns just after the edge where results appear.
  task automatic xfer(input logic [2:0] w, input logic en);
    s2     = w;
    enroll = en;
    etapa  = 2'b11;
    tick();
    etapa  = 2'b10;
    tick();
    tick();
    enroll = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    s2     = 3'b000;
    etapa  = 2'b00;
    enroll = 1'b0;
    #12;
    check("rst_granted", granted, 0);
    check("rst_denied", denied, 0);
    check("rst_locked", locked, 0);
    check("rst_enrolled", enrolled, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // No key yet: any word is rejected.
    xfer(3'b000, 1'b0);
    check("pre_denied", denied, 1);
    check("pre_fail_cnt", fail_cnt, 1);
    check("pre_granted", granted, 0);
    tick();
    check("pre_denied_pulse_end", denied, 0);

    // Enroll 101.
    xfer(3'b101, 1'b1);
    check("enr_enrolled", enrolled, 1);
    check("enr_granted", granted, 0);
    check("enr_denied", denied, 0);
    check("enr_fail_cnt", fail_cnt, 0);

    // Match, with a mismatching strobe inside the window that must be ignored.
    xfer(3'b101, 1'b0);
    check("match_granted", granted, 1);
    hc = 1;
    dn = 1'b0;
    s2 = 3'b011;
    for (int i = 0; i < 9; i++) begin
      if (i == 1) etapa = 2'b11;
      if (i == 2) etapa = 2'b10;
      tick();
      if (granted) hc++;
      dn = dn | denied;
    end
    check("grant_len", hc, 10);
    check("grant_ev_no_deny", dn, 0);
    check("grant_ev_fail_cnt", fail_cnt, 0);
    tick();
    check("grant_end", granted, 0);

    // Two mismatches then recovery.
    xfer(3'b011, 1'b0);
    check("mm1_denied", denied, 1);
    check("mm1_fail_cnt", fail_cnt, 1);
    xfer(3'b011, 1'b0);
    check("mm2_denied", denied, 1);
    check("mm2_fail_cnt", fail_cnt, 2);
    xfer(3'b101, 1'b0);
    check("rec_granted", granted, 1);
    check("rec_fail_cnt", fail_cnt, 0);
    for (int i = 0; i < 12 && granted; i++) tick();
    check("rec_grant_end", granted, 0);

    // Asynchronous reset in the middle of a grant.
    xfer(3'b101, 1'b0);
    check("rg_granted", granted, 1);
    #3 rst_n = 1'b0;
    #1;
    check("rg_granted_0", granted, 0);
    check("rg_denied_0", denied, 0);
    check("rg_locked_0", locked, 0);
    check("rg_enrolled_0", enrolled, 0);
    check("rg_fail_cnt_0", fail_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();
    // Key was cleared: the old key no longer matches.
    xfer(3'b101, 1'b0);
    check("post_rst_denied", denied, 1);
    check("post_rst_granted", granted, 0);
    check("post_rst_fail_cnt", fail_cnt, 1);

    // Lockout.
    xfer(3'b101, 1'b1);
    check("re_enr_fail_cnt", fail_cnt, 0);
    xfer(3'b011, 1'b0);
    check("lk1_fail_cnt", fail_cnt, 1);
    xfer(3'b011, 1'b0);
    check("lk2_fail_cnt", fail_cnt, 2);
    xfer(3'b011, 1'b0);
    check("lk3_fail_cnt", fail_cnt, 3);
    check("lk3_locked", locked, 1);
    check("lk3_denied", denied, 1);
    s2 = 3'b101;
    gr = 1'b0;
    dn = 1'b0;
`ifdef ACCESS_LOCK_STICKY_EN
    for (int i = 0; i < 100; i++) begin
      if (i == 0) etapa = 2'b11;
      if (i == 1) etapa = 2'b10;
      tick();
      gr = gr | granted;
    end
    check("sticky_locked", locked, 1);
    check("sticky_fail_cnt", fail_cnt, 3);
    check("sticky_no_grant", gr, 0);
    #3 rst_n = 1'b0;
    #1;
    check("sticky_rst_locked", locked, 0);
    check("sticky_rst_fail_cnt", fail_cnt, 0);
    tick();
    rst_n = 1'b1;
`else
    lc = 1;
    for (int i = 0; i < 40; i++) begin
      if (i == 0) etapa = 2'b11;
      if (i == 1) etapa = 2'b10;
      tick();
      gr = gr | granted;
      dn = dn | denied;
      if (!locked) break;
      if (i == 5) check("lk_hold_fail_cnt", fail_cnt, 3);
      lc++;
    end
    check("lock_len", lc, 20);
    check("lock_no_grant", gr, 0);
    check("lock_no_deny", dn, 0);
    check("unlock_locked", locked, 0);
    check("unlock_fail_cnt", fail_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
